dcache_port_arbiter: RTL and testbench

//  Shares one D$ request port between NR_PORTS LSU-side requesters (store buffer, load unit, PTW).

---
 rtl/dcache_port_arbiter_pkg.sv | 35 +++
 rtl/arb_id_fifo.sv | 56 +++++
 rtl/dcache_port_arbiter.sv | 115 +++++++++++
 tb/tb_dcache_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared payload types and constants for the D$ port arbiter.
// Request/response structs match the dcache requester interface.
package dcache_port_arbiter_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH         = 12;
    localparam int unsigned DCACHE_TAG_WIDTH           = 44;
    localparam int unsigned DCACHE_DATA_WIDTH          = 64;
    localparam int unsigned DCACHE_BE_WIDTH            = DCACHE_DATA_WIDTH / 8;
    localparam int unsigned DCACHE_ARB_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [DCACHE_DATA_WIDTH-1:0]  data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [DCACHE_BE_WIDTH-1:0]    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
        logic                          approx;
    } dcache_req_i_t;

    typedef struct packed {
        logic                         data_gnt;
        logic                         data_rvalid;
        logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
    } dcache_req_o_t;

    // Next round-robin start index after a grant to idx, modulo n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for reads that were granted but not yet answered.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_id_fifo
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DCACHE_ARB_MAX_OUTSTANDING,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) i_push |-> !o_full);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) i_pop |-> !o_empty);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one D$ request port between NR_PORTS requesters: round-robin index phase,
// tag/kill steered one cycle after a read grant, read responses routed in order.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 3,
    parameter int unsigned MAX_OUTSTANDING = DCACHE_ARB_MAX_OUTSTANDING
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t req_ports_i [NR_PORTS],
    output dcache_req_o_t req_ports_o [NR_PORTS],
    output dcache_req_i_t req_port_o,
    input  dcache_req_o_t req_port_i
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_lock;
    logic [IDX_W-1:0] r_tag;
    logic             r_lock_v;
    logic             r_tag_v;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_req;
    logic             w_gnt;
    logic             w_push;
    logic             w_pop;

    // Winner: held lock, else first requester scanning from r_rr (reverse loop keeps lowest offset).
    always_comb begin
        int unsigned j;
        j     = 0;
        w_win = r_lock;
        if (!r_lock_v) begin
            w_win = r_rr;
            for (int unsigned k = NR_PORTS; k > 0; k--) begin
                j = 32'(r_rr) + k - 32'd1;
                if (j >= NR_PORTS) j = j - NR_PORTS;
                if (req_ports_i[IDX_W'(j)].data_req) w_win = IDX_W'(j);
            end
        end
    end

    // A read is held back while the ID FIFO is full; writes never enter it.
    assign w_req  = rst_ni && req_ports_i[w_win].data_req
                    && !(!req_ports_i[w_win].data_we && w_full);
    assign w_gnt  = w_req && req_port_i.data_gnt;
    assign w_push = w_gnt && !req_ports_i[w_win].data_we;
    assign w_pop  = req_port_i.data_rvalid && !w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr     <= '0;
            r_lock   <= '0;
            r_lock_v <= 1'b0;
            r_tag    <= '0;
            r_tag_v  <= 1'b0;
        end else begin
            r_tag_v <= w_push;
            if (w_push) r_tag <= w_win;
            if (w_gnt) begin
                r_lock_v <= 1'b0;
                r_rr     <= IDX_W'(rr_next(32'(w_win), NR_PORTS));
            end else if (w_req) begin
                r_lock_v <= 1'b1;
                r_lock   <= w_win;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_win),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Index fields follow the winner; tag fields follow the read in its tag phase.
    always_comb begin
        req_port_o             = req_ports_i[w_win];
        req_port_o.data_req    = w_req;
        req_port_o.address_tag = r_tag_v ? req_ports_i[r_tag].address_tag
                                         : req_ports_i[w_win].address_tag;
        req_port_o.tag_valid   = r_tag_v && req_ports_i[r_tag].tag_valid;
        req_port_o.kill_req    = r_tag_v && req_ports_i[r_tag].kill_req;
        if (!rst_ni) req_port_o = '0;
    end

    always_comb begin
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            req_ports_o[i].data_gnt    = w_gnt && (w_win == IDX_W'(i));
            req_ports_o[i].data_rvalid = w_pop && (w_head == IDX_W'(i));
            req_ports_o[i].data_rdata  = rst_ni ? req_port_i.data_rdata : '0;
        end
    end

    a_lock_held:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     r_lock_v |-> req_ports_i[r_lock].data_req);
    a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     req_port_i.data_rvalid |-> !w_empty);
    a_gnt_req:      assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     w_gnt |-> req_port_o.data_req);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: reset, single read, round-robin, lock,
// FIFO-full stall, kill steering and mid-transaction reset.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst_n;

    dcache_req_i_t req_in  [NP];
    dcache_req_o_t req_out [NP];
    dcache_req_i_t dc_req;
    dcache_req_o_t dc_rsp;

    int checks   = 0;
    int failures = 0;

    logic [2:0] gv;
    logic [2:0] rv;
    assign gv = {req_out[2].data_gnt,    req_out[1].data_gnt,    req_out[0].data_gnt};
    assign rv = {req_out[2].data_rvalid, req_out[1].data_rvalid, req_out[0].data_rvalid};

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .NR_PORTS        (NP),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_ports_i (req_in),
        .req_ports_o (req_out),
        .req_port_o  (dc_req),
        .req_port_i  (dc_rsp)
    );

    task automatic clr_ports();
        for (int i = 0; i < NP; i++) req_in[i] = '0;
    endtask

    task automatic clr_in();
        clr_ports();
        dc_rsp = '0;
    endtask

    task automatic rd(input int p, input logic [DCACHE_INDEX_WIDTH-1:0] idx);
        req_in[p].data_req      = 1'b1;
        req_in[p].data_we       = 1'b0;
        req_in[p].address_index = idx;
        req_in[p].data_be       = '1;
        req_in[p].data_size     = 2'd3;
    endtask

    task automatic wr(input int p, input logic [DCACHE_DATA_WIDTH-1:0] d);
        req_in[p].data_req   = 1'b1;
        req_in[p].data_we    = 1'b1;
        req_in[p].data_wdata = d;
        req_in[p].data_be    = '1;
        req_in[p].data_size  = 2'd3;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_in();
        rst_n = 1'b0;
        req_in[0].data_req = 1'b1;
        wr(1, 64'h77);
        dc_rsp.data_gnt    = 1'b1;
        dc_rsp.data_rvalid = 1'b1;
        dc_rsp.data_rdata  = 64'h1234;
        @(negedge clk); #1;
        checks++; if (dc_req.data_req !== 1'b0) begin failures++; $display("FAIL rst_data_req: got %b expected 0", dc_req.data_req); end
        checks++; if (gv !== 3'b000) begin failures++; $display("FAIL rst_gnt: got %b expected 000", gv); end
        checks++; if (rv !== 3'b000) begin failures++; $display("FAIL rst_rvalid: got %b expected 000", rv); end
        checks++; if (req_out[0].data_rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", req_out[0].data_rdata); end
        checks++; if (dc_req.tag_valid !== 1'b0 || dc_req.kill_req !== 1'b0) begin failures++; $display("FAIL rst_tag_kill: got %b%b expected 00", dc_req.tag_valid, dc_req.kill_req); end
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (dc_req.data_req !== 1'b0 || dc_req.tag_valid !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got req=%b tv=%b expected 0 0", dc_req.data_req, dc_req.tag_valid); end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        rd(1, 12'h011);
        req_in[1].address_tag = 44'hABC;
        dc_rsp.data_gnt = 1'b1;
        #1;
        checks++; if (dc_req.data_req !== 1'b1) begin failures++; $display("FAIL single_req: got %b expected 1", dc_req.data_req); end
        checks++; if (dc_req.address_index !== 12'h011) begin failures++; $display("FAIL single_index: got %h expected 011", dc_req.address_index); end
        checks++; if (gv !== 3'b010) begin failures++; $display("FAIL single_gnt: got %b expected 010", gv); end
        @(negedge clk);
        req_in[1].data_req  = 1'b0;
        req_in[1].tag_valid = 1'b1;
        #1;
        checks++; if (dc_req.tag_valid !== 1'b1) begin failures++; $display("FAIL single_tag_valid: got %b expected 1", dc_req.tag_valid); end
        checks++; if (dc_req.address_tag !== 44'hABC) begin failures++; $display("FAIL single_tag: got %h expected abc", dc_req.address_tag); end
        @(negedge clk); #1;
        checks++; if (dc_req.tag_valid !== 1'b0) begin failures++; $display("FAIL single_tag_drop: got %b expected 0", dc_req.tag_valid); end
        req_in[1].tag_valid = 1'b0;
        @(negedge clk);
        dc_rsp.data_rvalid = 1'b1;
        dc_rsp.data_rdata  = 64'hDEAD_BEEF;
        #1;
        checks++; if (rv !== 3'b010) begin failures++; $display("FAIL single_rvalid: got %b expected 010", rv); end
        checks++; if (req_out[1].data_rdata !== 64'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata: got %h expected deadbeef", req_out[1].data_rdata); end
        @(negedge clk);
        dc_rsp.data_rvalid = 1'b0;
        #1;
        checks++; if (rv !== 3'b000) begin failures++; $display("FAIL single_rvalid_drop: got %b expected 000", rv); end
        clr_in();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) wr(i, 64'h100 + 64'(i));
            dc_rsp.data_gnt = 1'b1;
            #1;
            exp = 3'(1 << (k % 3));
            checks++; if (gv !== exp) begin failures++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, gv, exp); end
            checks++; if (dc_req.data_wdata !== 64'h100 + 64'(k % 3)) begin failures++; $display("FAIL rr_wdata_%0d: got %h expected %h", k, dc_req.data_wdata, 64'h100 + 64'(k % 3)); end
        end
        @(negedge clk);
        clr_in();
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        wr(2, 64'h2222);
        #1;
        checks++; if (dc_req.data_req !== 1'b1 || gv !== 3'b000) begin failures++; $display("FAIL lock_first: got req=%b gnt=%b expected 1 000", dc_req.data_req, gv); end
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            rd(0, 12'h0A0);
            #1;
            checks++; if (dc_req.data_we !== 1'b1 || dc_req.data_wdata !== 64'h2222) begin failures++; $display("FAIL lock_hold_%0d: got we=%b wdata=%h expected 1 2222", c, dc_req.data_we, dc_req.data_wdata); end
        end
        @(negedge clk);
        dc_rsp.data_gnt = 1'b1;
        #1;
        checks++; if (gv !== 3'b100) begin failures++; $display("FAIL lock_gnt2: got %b expected 100", gv); end
        @(negedge clk);
        req_in[2] = '0;
        #1;
        checks++; if (gv !== 3'b001 || dc_req.address_index !== 12'h0A0) begin failures++; $display("FAIL lock_then_p0: got gnt=%b idx=%h expected 001 0a0", gv, dc_req.address_index); end
        @(negedge clk);
        req_in[0].data_req = 1'b0;
        dc_rsp.data_gnt    = 1'b0;
        dc_rsp.data_rvalid = 1'b1;
        #1;
        checks++; if (rv !== 3'b001) begin failures++; $display("FAIL lock_rvalid: got %b expected 001", rv); end
        @(negedge clk);
        clr_in();
    endtask

    task automatic test_fifo_full();
        int         ord   [4] = '{0, 1, 2, 0};
        int         heads [4] = '{1, 2, 0, 0};
        logic [2:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clr_ports();
            rd(ord[k], 12'h040 + 12'(k));
            dc_rsp.data_gnt = 1'b1;
            #1;
            exp = 3'(1 << ord[k]);
            checks++; if (gv !== exp) begin failures++; $display("FAIL fill_gnt_%0d: got %b expected %b", k, gv, exp); end
        end
        @(negedge clk);
        clr_ports();
        rd(0, 12'h050);
        wr(1, 64'h1111);
        #1;
        checks++; if (gv !== 3'b010 || dc_req.data_we !== 1'b1) begin failures++; $display("FAIL full_write_gnt: got gnt=%b we=%b expected 010 1", gv, dc_req.data_we); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_in[1] = '0;
            #1;
            checks++; if (dc_req.data_req !== 1'b0 || gv !== 3'b000) begin failures++; $display("FAIL full_stall_%0d: got req=%b gnt=%b expected 0 000", c, dc_req.data_req, gv); end
        end
        @(negedge clk);
        dc_rsp.data_rvalid = 1'b1;
        #1;
        checks++; if (dc_req.data_req !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle: got %b expected 0", dc_req.data_req); end
        checks++; if (rv !== 3'b001) begin failures++; $display("FAIL full_pop_route: got %b expected 001", rv); end
        @(negedge clk);
        dc_rsp.data_rvalid = 1'b0;
        #1;
        checks++; if (dc_req.data_req !== 1'b1 || gv !== 3'b001) begin failures++; $display("FAIL full_release: got req=%b gnt=%b expected 1 001", dc_req.data_req, gv); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clr_ports();
            dc_rsp.data_rvalid = 1'b1;
            #1;
            exp = 3'(1 << heads[k]);
            checks++; if (rv !== exp) begin failures++; $display("FAIL drain_%0d: got %b expected %b", k, rv, exp); end
        end
        @(negedge clk);
        clr_in();
    endtask

    task automatic test_kill();
        int         heads [3] = '{0, 2, 1};
        logic [2:0] exp;
        do_reset();
        @(negedge clk);
        rd(0, 12'h001);
        dc_rsp.data_gnt = 1'b1;
        #1;
        checks++; if (gv !== 3'b001) begin failures++; $display("FAIL kill_gnt0: got %b expected 001", gv); end
        @(negedge clk);
        req_in[0].data_req  = 1'b0;
        req_in[0].tag_valid = 1'b1;
        rd(2, 12'h002);
        #1;
        checks++; if (gv !== 3'b100 || dc_req.kill_req !== 1'b0 || dc_req.tag_valid !== 1'b1) begin failures++; $display("FAIL kill_gnt2: got gnt=%b kill=%b tv=%b expected 100 0 1", gv, dc_req.kill_req, dc_req.tag_valid); end
        @(negedge clk);
        req_in[0]           = '0;
        req_in[2].data_req  = 1'b0;
        req_in[2].tag_valid = 1'b1;
        req_in[2].kill_req  = 1'b1;
        rd(1, 12'h003);
        #1;
        checks++; if (gv !== 3'b010) begin failures++; $display("FAIL kill_gnt1: got %b expected 010", gv); end
        checks++; if (dc_req.kill_req !== 1'b1) begin failures++; $display("FAIL kill_p2_tag: got %b expected 1", dc_req.kill_req); end
        @(negedge clk);
        req_in[1].data_req  = 1'b0;
        req_in[1].tag_valid = 1'b1;
        dc_rsp.data_gnt     = 1'b0;
        #1;
        checks++; if (dc_req.kill_req !== 1'b0 || dc_req.tag_valid !== 1'b1) begin failures++; $display("FAIL kill_p1_tag: got kill=%b tv=%b expected 0 1", dc_req.kill_req, dc_req.tag_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clr_ports();
            dc_rsp.data_rvalid = 1'b1;
            #1;
            exp = 3'(1 << heads[k]);
            checks++; if (rv !== exp) begin failures++; $display("FAIL kill_rvalid_%0d: got %b expected %b", k, rv, exp); end
        end
        @(negedge clk);
        clr_in();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        rd(0, 12'h010);
        dc_rsp.data_gnt = 1'b1;
        #1;
        checks++; if (gv !== 3'b001) begin failures++; $display("FAIL mid_gnt0: got %b expected 001", gv); end
        @(negedge clk);
        req_in[0] = '0;
        rd(1, 12'h011);
        #1;
        checks++; if (gv !== 3'b010) begin failures++; $display("FAIL mid_gnt1: got %b expected 010", gv); end
        @(negedge clk);
        rst_n               = 1'b0;
        req_in[1]           = '0;
        req_in[1].tag_valid = 1'b1;
        rd(2, 12'h012);
        dc_rsp.data_rvalid  = 1'b1;
        dc_rsp.data_rdata   = 64'h55;
        #1;
        checks++; if (dc_req.data_req !== 1'b0 || dc_req.tag_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_req: got req=%b tv=%b expected 0 0", dc_req.data_req, dc_req.tag_valid); end
        checks++; if (gv !== 3'b000 || rv !== 3'b000) begin failures++; $display("FAIL mid_rst_gnt_rv: got gnt=%b rv=%b expected 000 000", gv, rv); end
        checks++; if (req_out[2].data_rdata !== 64'h0) begin failures++; $display("FAIL mid_rst_rdata: got %h expected 0", req_out[2].data_rdata); end
        @(negedge clk);
        dc_rsp.data_rvalid = 1'b0;
        dc_rsp.data_rdata  = '0;
        rst_n              = 1'b1;
        #1;
        checks++; if (gv !== 3'b100) begin failures++; $display("FAIL mid_post_gnt2: got %b expected 100", gv); end
        checks++; if (dc_req.tag_valid !== 1'b0) begin failures++; $display("FAIL mid_post_tag: got %b expected 0", dc_req.tag_valid); end
        @(negedge clk);
        clr_ports();
        dc_rsp.data_gnt    = 1'b0;
        dc_rsp.data_rvalid = 1'b1;
        #1;
        checks++; if (rv !== 3'b100) begin failures++; $display("FAIL mid_post_rvalid: got %b expected 100", rv); end
        @(negedge clk);
        clr_in();
    endtask

    initial begin
        rst_n = 1'b1;
        clr_in();
        #2;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_kill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
